// File: rtl/uart_tx_reader.sv
// ---------------------------------------------------------------------------
// uart_tx_reader
//   UART 8N1 transmitter that drains the byte buffer written by the receive
//   path. Whenever the local read pointer differs from the receive side's
//   write pointer (and EN is high), the byte at the read pointer is fetched
//   and shifted out LSB first, CLKS_PER_BIT clocks per bit.
//
// Ports
//   i_Clock          system clock, rising edge
//   RESET            synchronous reset, active-high
//   EN               transmit enable, only looked at while idle
//   i_write_pointer  receive-side write pointer (next free slot)
//   i_mem_byte       buffer read data, one cycle after o_read_pointer settles
//   o_read_pointer   address of the next byte to send
//   o_TX_Serial      serial line, idles high
//   o_TX_Active      high for start, data and stop bits
//   o_TX_Done        one-cycle pulse after each completed frame
//   r_SM_Main        current state (debug)
// ---------------------------------------------------------------------------
module uart_tx_reader #(
   parameter int CLKS_PER_BIT = 50
) (
   input  logic        i_Clock,
   input  logic        RESET,
   input  logic        EN,
   input  logic [12:0] i_write_pointer,
   input  logic [7:0]  i_mem_byte,
   output logic [12:0] o_read_pointer,
   output logic        o_TX_Serial,
   output logic        o_TX_Active,
   output logic        o_TX_Done,
   output logic [2:0]  r_SM_Main
);

   typedef enum logic [2:0] {
      IDLE         = 3'b000,
      TX_FETCH     = 3'b001,
      TX_START_BIT = 3'b010,
      TX_DATA_BITS = 3'b011,
      TX_STOP_BIT  = 3'b100,
      TX_CLEANUP   = 3'b101
   } sm_t;

   localparam logic [7:0] CNT_LAST = 8'(CLKS_PER_BIT - 1);

   sm_t         sm_q, sm_n;
   logic [7:0]  clk_cnt_q, clk_cnt_n;
   logic [2:0]  bit_idx_q, bit_idx_n;
   logic [7:0]  tx_byte_q, tx_byte_n;
   logic [12:0] rd_ptr_n;
   logic        serial_n, active_n, done_n;

   assign r_SM_Main = sm_q;

   // State and output registers
   always_ff @(posedge i_Clock) begin
      if (RESET) begin
         sm_q           <= IDLE;
         clk_cnt_q      <= 8'd0;
         bit_idx_q      <= 3'd0;
         tx_byte_q      <= 8'h00;
         o_read_pointer <= 13'd0;
         o_TX_Serial    <= 1'b1;
         o_TX_Active    <= 1'b0;
         o_TX_Done      <= 1'b0;
      end else begin
         sm_q           <= sm_n;
         clk_cnt_q      <= clk_cnt_n;
         bit_idx_q      <= bit_idx_n;
         tx_byte_q      <= tx_byte_n;
         o_read_pointer <= rd_ptr_n;
         o_TX_Serial    <= serial_n;
         o_TX_Active    <= active_n;
         o_TX_Done      <= done_n;
      end
   end

   // Next-state and next-output logic
   always_comb begin
      sm_n      = sm_q;
      clk_cnt_n = clk_cnt_q;
      bit_idx_n = bit_idx_q;
      tx_byte_n = tx_byte_q;
      rd_ptr_n  = o_read_pointer;

      case (sm_q)
         IDLE: begin
            clk_cnt_n = 8'd0;
            // Equal pointers mean the buffer is empty; wrap is plain 13-bit.
            if (EN && (o_read_pointer != i_write_pointer))
               sm_n = TX_FETCH;
         end
         TX_FETCH: begin
            // Pointer has been stable since IDLE, so memory data is valid.
            tx_byte_n = i_mem_byte;
            sm_n      = TX_START_BIT;
         end
         TX_START_BIT: begin
            if (clk_cnt_q < CNT_LAST) begin
               clk_cnt_n = clk_cnt_q + 8'd1;
            end else begin
               clk_cnt_n = 8'd0;
               sm_n      = TX_DATA_BITS;
            end
         end
         TX_DATA_BITS: begin
            if (clk_cnt_q < CNT_LAST) begin
               clk_cnt_n = clk_cnt_q + 8'd1;
            end else begin
               clk_cnt_n = 8'd0;
               if (bit_idx_q != 3'd7) begin
                  bit_idx_n = bit_idx_q + 3'd1;
               end else begin
                  bit_idx_n = 3'd0;
                  sm_n      = TX_STOP_BIT;
               end
            end
         end
         TX_STOP_BIT: begin
            if (clk_cnt_q < CNT_LAST) begin
               clk_cnt_n = clk_cnt_q + 8'd1;
            end else begin
               clk_cnt_n = 8'd0;
               sm_n      = TX_CLEANUP;
            end
         end
         TX_CLEANUP: begin
            sm_n     = IDLE;
            rd_ptr_n = o_read_pointer + 13'd1;
         end
         default: begin
            sm_n      = IDLE;
            clk_cnt_n = 8'd0;
            bit_idx_n = 3'd0;
         end
      endcase

      // Outputs are decoded from the next state so that the registered line
      // changes on the same edge the state does.
      serial_n = 1'b1;
      active_n = 1'b0;
      done_n   = 1'b0;
      case (sm_n)
         TX_START_BIT: begin
            serial_n = 1'b0;
            active_n = 1'b1;
         end
         TX_DATA_BITS: begin
            serial_n = tx_byte_n[bit_idx_n];
            active_n = 1'b1;
         end
         TX_STOP_BIT: begin
            active_n = 1'b1;
         end
         TX_CLEANUP: begin
            done_n = 1'b1;
         end
         default: begin
            serial_n = 1'b1;
         end
      endcase
   end

endmodule

// File: tb/tb_uart_tx_reader.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_reader
//   Directed bench for uart_tx_reader. A synchronous buffer model feeds
//   i_mem_byte; each frame is compared cycle by cycle against the ideal
//   8N1 waveform and also decoded at mid-bit like a UART receiver.
// ---------------------------------------------------------------------------
module tb_uart_tx_reader;

   localparam int CPB    = 50;
   localparam int FRAME  = 10 * CPB;
   localparam int PERIOD = 10 * CPB + 3;

   logic        i_Clock;
   logic        RESET;
   logic        EN;
   logic [12:0] i_write_pointer;
   logic [7:0]  i_mem_byte;
   logic [12:0] o_read_pointer;
   logic        o_TX_Serial;
   logic        o_TX_Active;
   logic        o_TX_Done;
   logic [2:0]  r_SM_Main;

   logic [7:0]  mem [0:8191];

   int n_checks = 0;
   int n_pass   = 0;
   int cyc      = 0;
   int done_cnt = 0;
   int t_start  = 0;

   uart_tx_reader #(.CLKS_PER_BIT(CPB)) dut (
      .i_Clock         (i_Clock),
      .RESET           (RESET),
      .EN              (EN),
      .i_write_pointer (i_write_pointer),
      .i_mem_byte      (i_mem_byte),
      .o_read_pointer  (o_read_pointer),
      .o_TX_Serial     (o_TX_Serial),
      .o_TX_Active     (o_TX_Active),
      .o_TX_Done       (o_TX_Done),
      .r_SM_Main       (r_SM_Main)
   );

   initial i_Clock = 1'b0;
   always #5 i_Clock = ~i_Clock;

   always @(posedge i_Clock) begin
      cyc <= cyc + 1;
      if (o_TX_Done === 1'b1) done_cnt <= done_cnt + 1;
      i_mem_byte <= mem[o_read_pointer];
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   // Waits (bounded) for a start bit, then compares the whole frame against
   // the ideal waveform. Optionally drops EN at frame cycle drop_at.
   task automatic rx_frame(input logic [7:0] exp, input int drop_at, input string tag);
      int waited;
      int werr;
      int aerr;
      logic [7:0] dec;
      logic [9:0] bits;
      bits   = {1'b1, exp, 1'b0};
      waited = 0;
      werr   = 0;
      aerr   = 0;
      dec    = 8'h00;
      while (o_TX_Serial !== 1'b0 && waited < 3000) begin
         @(negedge i_Clock);
         waited++;
      end
      if (o_TX_Serial !== 1'b0) begin
         check({tag, "_start_timeout"}, 32'd0, 32'd1);
         return;
      end
      t_start = cyc;
      for (int i = 0; i < FRAME; i++) begin
         if (i > 0) @(negedge i_Clock);
         if (i == drop_at) EN = 1'b0;
         if (o_TX_Serial !== bits[i / CPB]) werr++;
         if (o_TX_Active !== 1'b1) aerr++;
         if ((i % CPB) == CPB / 2 && (i / CPB) >= 1 && (i / CPB) <= 8)
            dec[(i / CPB) - 1] = o_TX_Serial;
      end
      check({tag, "_wave_err"}, werr, 0);
      check({tag, "_active_err"}, aerr, 0);
      check({tag, "_byte"}, dec, exp);
   endtask

   // Cleanup cycle shows the done pulse; the cycle after shows the new pointer.
   task automatic after_frame(input logic [12:0] exp_ptr, input string tag);
      @(negedge i_Clock);
      check({tag, "_done"}, o_TX_Done, 1'b1);
      check({tag, "_active_off"}, o_TX_Active, 1'b0);
      @(negedge i_Clock);
      check({tag, "_done_off"}, o_TX_Done, 1'b0);
      check({tag, "_ptr"}, o_read_pointer, exp_ptr);
   endtask

   initial begin
      int viol;
      int d0;
      int starts [3];
      logic [7:0] seq [3];

      for (int a = 0; a < 8192; a++) mem[a] = 8'h00;
      RESET = 1'b1;
      EN = 1'b0;
      i_write_pointer = 13'd0;

      // Reset state
      repeat (3) @(negedge i_Clock);
      check("rst_serial", o_TX_Serial, 1'b1);
      check("rst_active", o_TX_Active, 1'b0);
      check("rst_done", o_TX_Done, 1'b0);
      check("rst_ptr", o_read_pointer, 13'd0);
      check("rst_state", r_SM_Main, 3'b000);

      // Empty buffer with EN high: nothing happens
      RESET = 1'b0;
      EN = 1'b1;
      viol = 0;
      for (int i = 0; i < 1000; i++) begin
         @(negedge i_Clock);
         if (o_TX_Serial !== 1'b1 || o_read_pointer !== 13'd0 || r_SM_Main !== 3'b000) viol++;
      end
      check("empty_idle", viol, 0);
      check("empty_done_cnt", done_cnt, 0);

      // Single byte 0xA5
      mem[0] = 8'hA5;
      i_write_pointer = 13'd1;
      d0 = done_cnt;
      rx_frame(8'hA5, -1, "a5");
      after_frame(13'd1, "a5");
      check("a5_done_cnt", done_cnt - d0, 1);
      @(negedge i_Clock);
      check("a5_state_idle", r_SM_Main, 3'b000);

      // Three back-to-back bytes
      seq[0] = 8'h00; seq[1] = 8'hFF; seq[2] = 8'h3C;
      mem[1] = seq[0]; mem[2] = seq[1]; mem[3] = seq[2];
      i_write_pointer = 13'd4;
      d0 = done_cnt;
      for (int k = 0; k < 3; k++) begin
         rx_frame(seq[k], -1, $sformatf("burst%0d", k));
         starts[k] = t_start;
         after_frame(13'(2 + k), $sformatf("burst%0d", k));
      end
      check("burst_period01", starts[1] - starts[0], PERIOD);
      check("burst_period12", starts[2] - starts[1], PERIOD);
      check("burst_done_cnt", done_cnt - d0, 3);
      repeat (5) @(negedge i_Clock);
      check("burst_state_idle", r_SM_Main, 3'b000);
      check("burst_line_high", o_TX_Serial, 1'b1);

      // EN dropped during data bit 3 with two bytes pending
      mem[4] = 8'h96;
      mem[5] = 8'h69;
      i_write_pointer = 13'd6;
      rx_frame(8'h96, 4 * CPB + 10, "endrop");
      after_frame(13'd5, "endrop");
      viol = 0;
      for (int i = 0; i < 1500; i++) begin
         @(negedge i_Clock);
         if (o_TX_Serial !== 1'b1 || r_SM_Main !== 3'b000 || o_read_pointer !== 13'd5) viol++;
      end
      check("endrop_hold", viol, 0);
      EN = 1'b1;
      rx_frame(8'h69, -1, "enresume");
      after_frame(13'd6, "enresume");

      // Pointer wrap 8191 -> 0 -> 1
      EN = 1'b0;
      mem[8191] = 8'h55;
      mem[0] = 8'hAA;
      i_write_pointer = 13'd8191;
      @(negedge i_Clock);
      force dut.o_read_pointer = 13'd8191;
      @(negedge i_Clock);
      release dut.o_read_pointer;
      repeat (2) @(negedge i_Clock);
      check("wrap_preload", o_read_pointer, 13'd8191);
      i_write_pointer = 13'd1;
      EN = 1'b1;
      rx_frame(8'h55, -1, "wrap55");
      after_frame(13'd0, "wrap55");
      rx_frame(8'hAA, -1, "wrapaa");
      after_frame(13'd1, "wrapaa");

      // Reset during data bit 5
      mem[1] = 8'hC3;
      i_write_pointer = 13'd2;
      viol = 0;
      while (o_TX_Serial !== 1'b0 && viol < 3000) begin
         @(negedge i_Clock);
         viol++;
      end
      check("rstmid_start", o_TX_Serial, 1'b0);
      repeat (6 * CPB + 10) @(negedge i_Clock);
      d0 = done_cnt;
      RESET = 1'b1;
      EN = 1'b0;
      @(negedge i_Clock);
      check("rstmid_serial", o_TX_Serial, 1'b1);
      check("rstmid_state", r_SM_Main, 3'b000);
      check("rstmid_ptr", o_read_pointer, 13'd0);
      check("rstmid_active", o_TX_Active, 1'b0);
      RESET = 1'b0;
      viol = 0;
      for (int i = 0; i < 3 * CPB; i++) begin
         @(negedge i_Clock);
         if (o_TX_Serial !== 1'b1) viol++;
      end
      check("rstmid_line_high", viol, 0);
      check("rstmid_no_done", done_cnt - d0, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
